// File: rtl/dfb_bus_pkg.sv
// Shared encodings for the 68030 bus-termination logic: FSM states,
// port-size codes and the DSACK pattern each port size answers with.
package dfb_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EXTWAIT,
    ST_UNCLAIMED,
    ST_ACK,
    ST_BERR,
    ST_HOLD
  } seq_state_t;

  localparam logic [1:0] PS_32 = 2'b00;
  localparam logic [1:0] PS_16 = 2'b01;
  localparam logic [1:0] PS_8  = 2'b10;

  localparam logic [1:0] DS_32   = 2'b00;
  localparam logic [1:0] DS_16   = 2'b01;
  localparam logic [1:0] DS_8    = 2'b10;
  localparam logic [1:0] DS_NONE = 2'b11;

  // Code 2'b11 is a legacy alias for a 16-bit port.
  function automatic logic [1:0] ds_pattern(input logic [1:0] ps);
    case (ps)
      PS_32:   return DS_32;
      PS_16:   return DS_16;
      PS_8:    return DS_8;
      default: return DS_16;
    endcase
  endfunction

endpackage

// File: rtl/dsack_sequencer_if.sv
// CPU-side bus signals seen by the termination engine; master is the
// 68030/decoder side, slave is the sequencer.
interface dsack_sequencer_if #(
  parameter int NREG = 4
);
  logic            AS;
  logic [NREG-1:0] HIT;
  logic            SLOW;
  logic [NREG-1:0] EXT_ACK;
  logic            BERR_EN;
  logic            CLR_FLAG;
  logic [1:0]      DSACK;
  logic            BERR;
  logic            BUSY;
  logic            TO_FLAG;
  logic [2:0]      REGION;

  modport master (
    output AS, HIT, SLOW, EXT_ACK, BERR_EN, CLR_FLAG,
    input  DSACK, BERR, BUSY, TO_FLAG, REGION
  );

  modport slave (
    input  AS, HIT, SLOW, EXT_ACK, BERR_EN, CLR_FLAG,
    output DSACK, BERR, BUSY, TO_FLAG, REGION
  );
endinterface

// File: rtl/ack_sync.sv
// Two-flop synchroniser for asynchronous acknowledge inputs; a raw change
// becomes visible to the sampling logic two clock edges later.
module ack_sync #(
  parameter int W = 1
) (
  input  logic         CPUCLK,
  input  logic         RESET,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge CPUCLK or posedge RESET) begin
    if (RESET) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dsack_sequencer.sv
// Bus-cycle termination engine: turns decoded region hits into registered
// DSACK/BERR using per-region wait tables or a timed external acknowledge.
module dsack_sequencer
  import dfb_bus_pkg::*;
#(
  parameter int                   NREG       = 4,
  parameter int                   WS_W       = 4,
  parameter logic [NREG*WS_W-1:0] WAITS_FAST = '0,
  parameter logic [NREG*WS_W-1:0] WAITS_SLOW = '0,
  parameter logic [NREG*2-1:0]    PORT       = '0,
  parameter logic [NREG-1:0]      MODE       = '0,
  parameter int                   TO_W       = 7,
  parameter int                   TIMEOUT    = 64
) (
  input logic               CPUCLK,
  input logic               RESET,
  dsack_sequencer_if.slave  bus
);

  // One counter serves both the wait countdown and the timeout count.
  localparam int CNT_W = (WS_W > TO_W) ? WS_W : TO_W;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       region_q, region_d;
  logic [1:0]       port_q, port_d;
  logic [1:0]       dsack_q;
  logic             berr_q;
  logic             to_flag_q;

  logic [NREG-1:0]  ext_ack_s;
  logic             ext_ack_sel;
  logic             hit_found;
  logic             hit_mode;
  logic [2:0]       hit_idx;
  logic [1:0]       hit_port;
  logic [WS_W-1:0]  hit_wait;

  ack_sync #(.W(NREG)) u_ack_sync (
    .CPUCLK (CPUCLK),
    .RESET  (RESET),
    .d      (bus.EXT_ACK),
    .q      (ext_ack_s)
  );

  // Lowest-index hit wins, so scan downwards and let later matches overwrite.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    hit_port  = PS_32;
    hit_mode  = 1'b0;
    hit_wait  = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (bus.HIT[i]) begin
        hit_found = 1'b1;
        hit_idx   = 3'(i);
        hit_port  = PORT[i*2 +: 2];
        hit_mode  = MODE[i];
        hit_wait  = bus.SLOW ? WAITS_SLOW[i*WS_W +: WS_W] : WAITS_FAST[i*WS_W +: WS_W];
      end
    end
    ext_ack_sel = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (region_q == 3'(i)) ext_ack_sel = ext_ack_s[i];
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = region_q;
    port_d   = port_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.AS) begin
          if (hit_found) begin
            region_d = hit_idx;
            port_d   = hit_port;
            if (hit_mode) begin
              state_d = ST_EXTWAIT;
              cnt_d   = '0;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = CNT_W'(hit_wait);
            end
          end else if (bus.BERR_EN) begin
            state_d = ST_UNCLAIMED;
            cnt_d   = '0;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_EXTWAIT: begin
        if (ext_ack_sel)             state_d = ST_ACK;
        else if (cnt_q == TO_LAST)   state_d = ST_BERR;
        else                         cnt_d   = cnt_inc;
      end
      ST_UNCLAIMED: begin
        if (cnt_q == TO_LAST) state_d = ST_BERR;
        else                  cnt_d   = cnt_inc;
      end
      default: ;
    endcase
    // AS negation ends any cycle, including one about to be acknowledged.
    if (state_q != ST_IDLE && bus.AS) state_d = ST_IDLE;
  end

  always_ff @(posedge CPUCLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      region_q  <= '0;
      port_q    <= PS_32;
      dsack_q   <= DS_NONE;
      berr_q    <= 1'b1;
      to_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      region_q  <= region_d;
      port_q    <= port_d;
      dsack_q   <= (state_d == ST_ACK) ? ds_pattern(port_d) : DS_NONE;
      berr_q    <= (state_d != ST_BERR);
      if (state_d == ST_BERR && state_q != ST_BERR) to_flag_q <= 1'b1;
      else if (bus.CLR_FLAG)                         to_flag_q <= 1'b0;
    end
  end

  assign bus.DSACK   = dsack_q;
  assign bus.BERR    = berr_q;
  assign bus.BUSY    = (state_q != ST_IDLE);
  assign bus.TO_FLAG = to_flag_q;
  assign bus.REGION  = region_q;

endmodule

// File: tb/tb_dsack_sequencer.sv
// Self-checking bench for dsack_sequencer: directed timing cases plus
// randomized bus cycles compared each cycle against a cycle-level model.
module tb_dsack_sequencer;

  localparam int NREG    = 4;
  localparam int WS_W    = 4;
  localparam int TO_W    = 7;
  localparam int TIMEOUT = 8;
  localparam logic [15:0] WAITS_FAST = 16'h0032;
  localparam logic [15:0] WAITS_SLOW = 16'h5061;
  localparam logic [7:0]  PORT       = 8'hE4;
  localparam logic [3:0]  MODE       = 4'b0100;

  // The same configuration, written per region for the model.
  int fast_tab [4] = '{2, 3, 0, 0};
  int slow_tab [4] = '{1, 6, 0, 5};
  int size_tab [4] = '{32, 16, 8, 16};
  bit ext_tab  [4] = '{0, 0, 1, 0};

  localparam int K_FIXED = 0, K_EXT = 1, K_UNCL = 2, K_HOLD = 3;
  localparam int R_NONE = 0, R_ACK = 1, R_BERR = 2;

  logic CPUCLK = 1'b0;
  logic RESET  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  dsack_sequencer_if #(.NREG(NREG)) tb_if ();

  dsack_sequencer #(
    .NREG(NREG), .WS_W(WS_W), .WAITS_FAST(WAITS_FAST), .WAITS_SLOW(WAITS_SLOW),
    .PORT(PORT), .MODE(MODE), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CPUCLK (CPUCLK),
    .RESET  (RESET),
    .bus    (tb_if)
  );

  always #5 CPUCLK = ~CPUCLK;

  function automatic logic [1:0] size_code(input int bits);
    case (bits)
      32:      return 2'b00;
      8:       return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  // Model: tracks each bus cycle by elapsed edges since it started.
  int         now_edge = 0;
  bit         m_active = 0;
  int         m_kind = K_HOLD, m_e0 = 0, m_resp = R_NONE, m_region = 0, m_wait = 0;
  int         found, elapsed;
  bit         flag_set;
  logic [3:0] seen;
  logic [3:0] ack_at [int];
  logic [1:0] exp_dsack = 2'b11;
  logic       exp_berr = 1'b1, exp_busy = 1'b0, exp_flag = 1'b0;
  logic [2:0] exp_region = 3'd0;

  always @(posedge CPUCLK or posedge RESET) begin
    if (RESET) begin
      m_active = 0; m_resp = R_NONE;
      exp_dsack = 2'b11; exp_berr = 1'b1; exp_busy = 1'b0;
      exp_flag = 1'b0; exp_region = 3'd0;
      ack_at.delete();
    end else begin
      flag_set = 0;
      now_edge++;
      if (m_active) begin
        if (tb_if.AS) begin
          m_active = 0; m_resp = R_NONE;
        end else if (m_resp == R_NONE) begin
          elapsed = now_edge - m_e0;
          seen = ack_at.exists(now_edge - 2) ? ack_at[now_edge - 2] : 4'b0;
          case (m_kind)
            K_FIXED: if (elapsed == m_wait + 1) m_resp = R_ACK;
            K_EXT: begin
              if (seen[m_region]) m_resp = R_ACK;
              else if (elapsed == TIMEOUT) begin m_resp = R_BERR; flag_set = 1; end
            end
            K_UNCL: if (elapsed == TIMEOUT) begin m_resp = R_BERR; flag_set = 1; end
            default: ;
          endcase
        end
      end else if (!tb_if.AS) begin
        m_active = 1; m_e0 = now_edge; m_resp = R_NONE;
        found = -1;
        for (int i = 0; i < NREG; i++) if (found < 0 && tb_if.HIT[i]) found = i;
        if (found >= 0) begin
          m_region   = found;
          exp_region = 3'(found);
          m_kind     = ext_tab[found] ? K_EXT : K_FIXED;
          m_wait     = tb_if.SLOW ? slow_tab[found] : fast_tab[found];
        end else begin
          m_kind = tb_if.BERR_EN ? K_UNCL : K_HOLD;
        end
      end
      ack_at[now_edge] = tb_if.EXT_ACK;
      if (flag_set) exp_flag = 1'b1;
      else if (tb_if.CLR_FLAG) exp_flag = 1'b0;
      exp_busy  = m_active;
      exp_dsack = (m_active && m_resp == R_ACK) ? size_code(size_tab[m_region]) : 2'b11;
      exp_berr  = !(m_active && m_resp == R_BERR);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("model_DSACK",   {6'b0, tb_if.DSACK},   {6'b0, exp_dsack});
    checkOutput("model_BERR",    {7'b0, tb_if.BERR},    {7'b0, exp_berr});
    checkOutput("model_BUSY",    {7'b0, tb_if.BUSY},    {7'b0, exp_busy});
    checkOutput("model_TO_FLAG", {7'b0, tb_if.TO_FLAG}, {7'b0, exp_flag});
    checkOutput("model_REGION",  {5'b0, tb_if.REGION},  {5'b0, exp_region});
  endtask

  // Every clock step goes through here, so the model is compared each cycle.
  task automatic tick();
    @(negedge CPUCLK);
    compareModel();
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic as, input logic [3:0] hit, input logic slow,
                               input logic berr_en, input logic [3:0] ext, input logic clr);
    tb_if.AS = as; tb_if.HIT = hit; tb_if.SLOW = slow;
    tb_if.BERR_EN = berr_en; tb_if.EXT_ACK = ext; tb_if.CLR_FLAG = clr;
  endtask

  task automatic endCycle();
    tb_if.AS = 1'b1;
    tb_if.EXT_ACK = '0;
    tick();
  endtask

  initial begin
    applyStimulus(1, 4'b0, 0, 0, 4'b0, 0);
    runTicks(2);
    checkOutput("reset_DSACK",   {6'b0, tb_if.DSACK},   8'h03);
    checkOutput("reset_BERR",    {7'b0, tb_if.BERR},    8'h01);
    checkOutput("reset_BUSY",    {7'b0, tb_if.BUSY},    8'h00);
    checkOutput("reset_TO_FLAG", {7'b0, tb_if.TO_FLAG}, 8'h00);
    checkOutput("reset_REGION",  {5'b0, tb_if.REGION},  8'h00);
    RESET = 1'b0;
    runTicks(2);

    // Fixed wait, region 1, W=3, 16-bit port.
    applyStimulus(0, 4'b0010, 0, 0, 4'b0, 0);
    runTicks(4);
    checkOutput("fixed_before", {6'b0, tb_if.DSACK}, 8'h03);
    tick();
    checkOutput("fixed_ack", {6'b0, tb_if.DSACK}, 8'h01);
    checkOutput("fixed_region", {5'b0, tb_if.REGION}, 8'h01);
    runTicks(3);
    checkOutput("fixed_held", {6'b0, tb_if.DSACK}, 8'h01);
    endCycle();
    checkOutput("fixed_release", {6'b0, tb_if.DSACK}, 8'h03);
    checkOutput("fixed_idle", {7'b0, tb_if.BUSY}, 8'h00);
    tick();

    // Slow table W=6; SLOW toggled mid-cycle must not matter.
    applyStimulus(0, 4'b0010, 1, 0, 4'b0, 0);
    runTicks(2);
    tb_if.SLOW = 1'b0;
    runTicks(5);
    checkOutput("slow_before", {6'b0, tb_if.DSACK}, 8'h03);
    tick();
    checkOutput("slow_ack", {6'b0, tb_if.DSACK}, 8'h01);
    endCycle();
    tick();

    // External acknowledge, region 2, 8-bit port.
    applyStimulus(0, 4'b0100, 0, 0, 4'b0, 0);
    runTicks(5);
    tb_if.EXT_ACK = 4'b0100;
    runTicks(2);
    checkOutput("ext_before", {6'b0, tb_if.DSACK}, 8'h03);
    tick();
    checkOutput("ext_ack", {6'b0, tb_if.DSACK}, 8'h02);
    checkOutput("ext_berr", {7'b0, tb_if.BERR}, 8'h01);
    checkOutput("ext_flag", {7'b0, tb_if.TO_FLAG}, 8'h00);
    endCycle();
    runTicks(2);

    // Timeout on an external cycle, then flag clear.
    applyStimulus(0, 4'b0100, 0, 0, 4'b0, 0);
    runTicks(8);
    checkOutput("to_before", {7'b0, tb_if.BERR}, 8'h01);
    tick();
    checkOutput("to_berr", {7'b0, tb_if.BERR}, 8'h00);
    checkOutput("to_dsack", {6'b0, tb_if.DSACK}, 8'h03);
    checkOutput("to_flag", {7'b0, tb_if.TO_FLAG}, 8'h01);
    endCycle();
    tb_if.CLR_FLAG = 1'b1;
    tick();
    checkOutput("to_clear", {7'b0, tb_if.TO_FLAG}, 8'h00);
    tb_if.CLR_FLAG = 1'b0;
    tick();

    // Set and clear on the same edge: set wins.
    applyStimulus(0, 4'b0100, 0, 0, 4'b0, 0);
    runTicks(8);
    tb_if.CLR_FLAG = 1'b1;
    tick();
    checkOutput("to_set_wins", {7'b0, tb_if.TO_FLAG}, 8'h01);
    tb_if.CLR_FLAG = 1'b0;
    endCycle();
    tick();

    // Unclaimed with timeout enabled.
    applyStimulus(0, 4'b0000, 0, 1, 4'b0, 0);
    runTicks(8);
    checkOutput("uncl_before", {7'b0, tb_if.BERR}, 8'h01);
    tick();
    checkOutput("uncl_berr", {7'b0, tb_if.BERR}, 8'h00);
    endCycle();
    tick();

    // Unclaimed with timeout disabled: hold with no response.
    applyStimulus(0, 4'b0000, 0, 0, 4'b0, 0);
    runTicks(200);
    checkOutput("hold_dsack", {6'b0, tb_if.DSACK}, 8'h03);
    checkOutput("hold_berr", {7'b0, tb_if.BERR}, 8'h01);
    checkOutput("hold_busy", {7'b0, tb_if.BUSY}, 8'h01);
    endCycle();
    checkOutput("hold_release", {7'b0, tb_if.BUSY}, 8'h00);
    tick();

    // Priority: lowest set HIT bit selects region 1.
    applyStimulus(0, 4'b0110, 0, 0, 4'b0, 0);
    tick();
    checkOutput("prio_region", {5'b0, tb_if.REGION}, 8'h01);
    runTicks(3);
    checkOutput("prio_before", {6'b0, tb_if.DSACK}, 8'h03);
    tick();
    checkOutput("prio_ack", {6'b0, tb_if.DSACK}, 8'h01);
    endCycle();
    tick();

    // Abort: region 3 slow W=5, AS rises at E0+2.
    applyStimulus(0, 4'b1000, 1, 0, 4'b0, 0);
    runTicks(2);
    tb_if.AS = 1'b1;
    tick();
    checkOutput("abort_idle", {7'b0, tb_if.BUSY}, 8'h00);
    runTicks(8);
    checkOutput("abort_no_ack", {6'b0, tb_if.DSACK}, 8'h03);

    // Zero wait states: acknowledge right after E0+1.
    applyStimulus(0, 4'b1000, 0, 0, 4'b0, 0);
    tick();
    checkOutput("w0_before", {6'b0, tb_if.DSACK}, 8'h03);
    tick();
    checkOutput("w0_ack", {6'b0, tb_if.DSACK}, 8'h01);
    endCycle();
    tick();

    // Asynchronous reset during ACK.
    applyStimulus(0, 4'b0001, 0, 0, 4'b0, 0);
    runTicks(4);
    checkOutput("rst_pre_ack", {6'b0, tb_if.DSACK}, 8'h00);
    #2 RESET = 1'b1;
    #1;
    checkOutput("rst_async_dsack", {6'b0, tb_if.DSACK}, 8'h03);
    checkOutput("rst_async_busy", {7'b0, tb_if.BUSY}, 8'h00);
    checkOutput("rst_async_flag", {7'b0, tb_if.TO_FLAG}, 8'h00);
    tick();
    RESET = 1'b0;
    tb_if.AS = 1'b1;
    runTicks(2);

    // Randomized cycles against the model.
    for (int n = 0; n < 150; n++) begin
      automatic logic [3:0] hit;
      automatic int len, ext_start, gap;
      hit = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      len = $urandom_range(1, 20);
      ext_start = $urandom_range(0, 16);
      gap = $urandom_range(1, 4);
      applyStimulus(0, hit, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'b0, 0);
      for (int k = 0; k < len; k++) begin
        tick();
        if (k >= ext_start) tb_if.EXT_ACK = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) tb_if.HIT = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) tb_if.SLOW = ~tb_if.SLOW;
      end
      tb_if.AS = 1'b1;
      tb_if.EXT_ACK = '0;
      for (int k = 0; k < gap; k++) begin
        tb_if.CLR_FLAG = ($urandom_range(0, 5) == 0);
        tick();
      end
      tb_if.CLR_FLAG = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsack_sequencer.md
Name: dsack_sequencer

Overview:
- Parametrised bus-cycle termination engine for the 68030 side of the accelerator.
- Takes NREG externally decoded address-region hits.
- Generates registered active-low DSACK[1:0] and BERR using, per region:
  - a fixed wait-state count (fast or slow table), or
  - a synchronised external acknowledge with bus-error timeout.
- Covers unclaimed cycles with an optional no-response bus-error timeout.
- Replaces the hand-built per-source AS-delay chains and ad hoc berr counter with one configurable block running on CPUCLK.

Parameters:
NREG, 4, number of decoded regions (1..8)
WS_W, 4, width of one wait-state field
WAITS_FAST, 0, packed NREG*WS_W wait counts used when SLOW=0 (region i at [i*WS_W +: WS_W])
WAITS_SLOW, 0, packed NREG*WS_W wait counts used when SLOW=1
PORT, 0, packed NREG*2 port size: 00=32-bit, 01=16-bit, 10=8-bit, 11=16-bit
MODE, 0, packed NREG bits: 0=fixed wait, 1=external acknowledge
TO_W, 7, timeout counter width
TIMEOUT, 64, cycles before BERR in external or unclaimed cycles (1..2^TO_W-1)

Ports:
CPUCLK  in  1  block clock, rising edge
RESET  in  1  asynchronous, active-high reset
AS  in  1  68030 address strobe, active low, synchronous to CPUCLK
HIT  in  NREG  region decode, active high, valid while AS low
SLOW  in  1  select WAITS_SLOW table, sampled at cycle start
EXT_ACK  in  NREG  per-region external acknowledge, active high, asynchronous
BERR_EN  in  1  enable timeout for unclaimed cycles, sampled at cycle start
CLR_FLAG  in  1  clears TO_FLAG
DSACK  out  2  data/size acknowledge, active low
BERR  out  1  bus error, active low
BUSY  out  1  high in any state other than IDLE
TO_FLAG  out  1  sticky: a timeout BERR occurred
REGION  out  3  index of last claimed region

Behaviour:
- Reset values: DSACK=2'b11, BERR=1, BUSY=0, TO_FLAG=0, REGION=0, state IDLE, counters 0, synchronisers 0.
- RESET asserted mid-cycle negates DSACK and BERR immediately (asynchronous).
- All outputs are registered; no combinational path from input to output.
- States: IDLE, WAIT, EXTWAIT, UNCLAIMED, ACK, BERR, HOLD.
- IDLE, AS seen low at edge E0:
  - Select the lowest-index set HIT bit as region r. Latch r, PORT[r], and the wait count from the table chosen by SLOW.
  - MODE[r]=0 -> WAIT, count = wait value.
  - MODE[r]=1 -> EXTWAIT, timeout counter = 0.
  - No HIT and BERR_EN=1 -> UNCLAIMED, counter = 0.
  - No HIT and BERR_EN=0 -> HOLD, no response.
- WAIT: decrement each edge. When count is 0, go to ACK.
  - Latency: DSACK low after edge E0+1+W. W=0 gives DSACK low after E0+1.
- EXT_ACK path: each bit has a two-flop synchroniser, so raw assertion takes 2 edges to appear.
- EXTWAIT: counter increments each edge.
  - Synchronised EXT_ACK[r]=1 -> ACK.
  - Otherwise counter == TIMEOUT-1 -> BERR.
  - If both conditions hold on the same edge, ACK wins.
- UNCLAIMED: counter increments each edge; counter == TIMEOUT-1 -> BERR.
- ACK: DSACK = 00 for a 32-bit port, 01 for 16-bit, 10 for 8-bit. Held while AS low.
- BERR: BERR=0 and DSACK=11. TO_FLAG set. Held while AS low.
- HOLD: outputs stay inactive until AS is high.
- Any non-IDLE state with AS sampled high -> IDLE.
  - DSACK and BERR negate on that same edge.
  - A cycle aborted before ACK produces no acknowledge and does not set TO_FLAG.
- AS must be seen high for at least one edge before a new cycle starts. Back-to-back cycles therefore always pass through IDLE.
- HIT, SLOW and BERR_EN changing after E0 are ignored until the next cycle.
- TO_FLAG: set has priority over CLR_FLAG on the same edge.
- Counter arithmetic is unsigned, width TO_W. The counter saturates and never wraps.
- REGION updates at E0 for claimed cycles only.

Decomposition:
- Package dfb_bus_pkg holds:
  - state encoding;
  - port-size codes (PS_32=00, PS_16=01, PS_8=10);
  - DSACK patterns per size (DS_32=2'b00, DS_16=2'b01, DS_8=2'b10, DS_NONE=2'b11);
  - a function mapping a port-size code to its DSACK pattern.
- One sub-module, ack_sync: a two-flop synchroniser, width-parametrised, reset to 0 by RESET. Instantiated once, NREG wide, for EXT_ACK.
- Priority encoder and table slicing stay inline in dsack_sequencer.

Test Plan:
- Fixed wait: MODE=0, region 1, WAITS_FAST[1]=3, PORT=01, SLOW=0, AS low at E0 -> DSACK=01 after E0+4; held until AS rises; returns to 11 on the next edge.
- Slow table: same cycle with SLOW=1 and WAITS_SLOW[1]=6 -> DSACK=01 after E0+7. Toggle SLOW at E0+2 -> timing unchanged.
- External acknowledge: MODE[2]=1, PORT=10, EXT_ACK[2] rises between E0+4 and E0+5 -> DSACK=10 after E0+7; BERR stays 1; TO_FLAG stays 0.
- Timeout: TIMEOUT=8, EXT_ACK never asserted -> BERR=0 after E0+8, TO_FLAG=1. CLR_FLAG pulse -> TO_FLAG=0. Set and clear on the same edge -> TO_FLAG stays 1.
- Unclaimed cycle: HIT=0, BERR_EN=1 -> BERR after TIMEOUT edges. With BERR_EN=0 -> no DSACK or BERR for 200 cycles, BUSY=1 until AS rises.
- Priority and abort:
  - HIT=4'b0110 -> REGION=1, region-1 timing used.
  - AS rising at E0+2 with WAIT=5 -> no DSACK, IDLE on the next edge.
  - RESET asserted during ACK -> DSACK=11 without waiting for a clock edge.
